// File: rtl/mod_updown_counter.sv
// Loadable up/down modulo counter with wrap or saturate boundaries, terminal-count pulse
// and sticky overflow. Define MOD_UPDOWN_COUNTER_CAPTURE_EN to add the capture/cap_val port pair.
module mod_updown_counter #(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] modulo,
    input  logic             clr_ovf,
`ifdef MOD_UPDOWN_COUNTER_CAPTURE_EN
    input  logic             capture,
    output logic [WIDTH-1:0] cap_val,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] out_d;
    logic             boundary;
    logic             wrap;

    always_comb begin
        out_d    = out;
        boundary = 1'b0;
        if (load) begin
            out_d = load_val;
        end else if (enable) begin
            if (up_dn) begin
                if (out < modulo) begin
                    out_d = out + 1'b1;
                end else begin
                    // Also covers out above a lowered modulo: treated as reaching the top.
                    boundary = 1'b1;
                    out_d    = sat_mode ? out : '0;
                end
            end else begin
                if (out != '0) begin
                    out_d = out - 1'b1;
                end else begin
                    boundary = 1'b1;
                    out_d    = sat_mode ? '0 : modulo;
                end
            end
        end
    end

    assign wrap = boundary & ~sat_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= RESET_VAL;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            out <= out_d;
            tc  <= boundary;
            // Set has priority over clear on the same edge.
            if (wrap) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef MOD_UPDOWN_COUNTER_CAPTURE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_val <= '0;
        end else if (capture) begin
            cap_val <= out;
        end
    end
`endif

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter and data width in bits (>= 2).
REQ-002 Parameter RESET_VAL, default 0, value loaded into out on reset.
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port enable  input  1  count enable.
REQ-006 Port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-007 Port sat_mode  input  1  boundary mode: 0 = wrap, 1 = saturate/hold.
REQ-008 Port load  input  1  synchronous load strobe.
REQ-009 Port load_val  input  WIDTH  value written to out on load.
REQ-010 Port modulo  input  WIDTH  terminal (maximum) count; range is 0..modulo.
REQ-011 Port clr_ovf  input  1  clears sticky ovf.
REQ-012 Port out  output  WIDTH  registered count value.
REQ-013 Port tc  output  1  registered one-cycle terminal-count pulse.
REQ-014 Port ovf  output  1  sticky wrap flag.

Function
REQ-015 Update priority per edge SHALL be: load > enable > hold.
REQ-016 load=1: out <= load_val, whatever enable, up_dn or modulo is; tc <= 0; no boundary event.
REQ-017 enable=1, up_dn=1, out < modulo: out <= out + 1.
REQ-018 enable=1, up_dn=1, out >= modulo: boundary event; out <= 0 if sat_mode=0, else out <= out (hold).
REQ-019 enable=1, up_dn=0, out != 0: out <= out - 1, also when out > modulo.
REQ-020 enable=1, up_dn=0, out == 0: boundary event; out <= modulo if sat_mode=0, else out <= 0 (hold).
REQ-021 enable=0 and load=0: out holds; tc <= 0.
REQ-022 tc SHALL be 1 exactly in the cycle after an edge that had a boundary event, else 0; consecutive events give consecutive tc cycles.
REQ-023 A boundary event with sat_mode=0 (a wrap) SHALL set ovf; saturating events SHALL NOT set ovf.
REQ-024 ovf SHALL stay set until clr_ovf=1; if a wrap and clr_ovf occur on the same edge, ovf SHALL be 1 (set wins).
REQ-025 modulo=0: out stays 0 while enabled; every enabled edge is a boundary event.
REQ-026 modulo, sat_mode and up_dn SHALL be sampled every edge; changing them mid-count takes effect on the next edge with no extra latency.
REQ-027 All arithmetic SHALL be modulo 2^WIDTH on unsigned values; no carry-out port.

Reset
REQ-028 reset=1 SHALL immediately, without a clock edge, force out = RESET_VAL, tc = 0, ovf = 0 (and cap_val = 0 when compiled in).
REQ-029 Reset asserted mid-count SHALL abort the count; after deassertion the first enabled edge counts from RESET_VAL.
REQ-030 While reset=1, load, enable and clr_ovf SHALL have no effect.

Configuration
REQ-031 Macro MOD_UPDOWN_COUNTER_CAPTURE_EN, when defined, SHALL add input capture (1 bit) and output cap_val (WIDTH).
REQ-032 With the macro: capture=1 on an edge SHALL store the pre-update out value into cap_val; cap_val holds otherwise; capture works regardless of enable and load.
REQ-033 Without the macro: capture and cap_val ports and their register SHALL NOT exist; all other behaviour is identical.

Verification
REQ-034 WIDTH=8, modulo=9, up, sat_mode=0, enable held for 12 cycles from 0 -> out 1..9,0,1,2; tc high the one cycle after the edge 9->0; ovf=1.
REQ-035 modulo=9, down, sat_mode=1, from 2, enable for 4 cycles -> out 1,0,0,0; tc high on the last two of those cycles; ovf stays 0.
REQ-036 load=1 and enable=1 on the same edge, load_val=0x55 -> out=0x55, tc=0; then up with modulo=0x20 -> out 0x00 and tc pulse (out >= modulo wraps).
REQ-037 Wrap and clr_ovf on the same edge -> ovf=1; next edge clr_ovf=1, no wrap -> ovf=0.
REQ-038 reset asserted asynchronously between edges at out=7 with RESET_VAL=3 -> out=3, tc=0, ovf=0 before the next edge; first enabled up edge after release -> out=4.
REQ-039 With MOD_UPDOWN_COUNTER_CAPTURE_EN, capture=1 on the edge where out goes 5->6 -> cap_val=5; with the macro undefined, the build has no cap_val port.
